// File: rtl/inst_sequencer.sv
// Instruction sequencer: holds a loadable program store, steps a program
// counter through it and issues one decoded instruction per cycle to the
// pipeline. Read-after-write hazards on recently issued destinations are
// blocked with bubbles; after the last instruction a fixed number of
// bubbles drains the pipeline, then done pulses for one cycle.
// Ports:
//   clk, rstN            clock (rising edge), async active-low reset
//   load_en/addr/data    program store write, accepted in IDLE or DONE
//   prog_len, start      run length (clamped to PROG_DEPTH) and run request
//   i_op/i_waddr/i_raddr1/i_raddr2/i_valid  issued instruction or bubble
//   pc                   index of the next instruction to issue
//   busy, done           run in progress / one-cycle completion pulse
module inst_sequencer #(
  parameter int unsigned PROG_DEPTH   = 32,
  parameter int unsigned PC_W         = 5,
  parameter int unsigned HAZARD_DEPTH = 3,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_addr,
  input  logic [16:0]     load_data,
  input  logic [PC_W:0]   prog_len,
  input  logic            start,
  output logic [1:0]      i_op,
  output logic [4:0]      i_waddr,
  output logic [4:0]      i_raddr1,
  output logic [4:0]      i_raddr2,
  output logic            i_valid,
  output logic [PC_W:0]   pc,
  output logic            busy,
  output logic            done
);

  localparam int unsigned IW   = 17;
  localparam int unsigned RW   = 5;
  localparam int unsigned DC_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [PC_W:0]   pc_d, len_q, len_d, len_clamped;
  logic [DC_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]   hist_a_q [HAZARD_DEPTH];
  logic [RW-1:0]   hist_a_d [HAZARD_DEPTH];
  logic            hist_v_q [HAZARD_DEPTH];
  logic            hist_v_d [HAZARD_DEPTH];
  logic [IW-1:0]   store [PROG_DEPTH];
  logic [IW-1:0]   instr;
  logic [RW-1:0]   ins_w, ins_r1, ins_r2;
  logic            hazard, shift, shift_v, hist_clr;
  logic [RW-1:0]   shift_a;
  logic [1:0]      op_d;
  logic [RW-1:0]   waddr_d, raddr1_d, raddr2_d;
  logic            valid_d, busy_d, done_d;

  // Program store: not reset, writable only while no run is active
  always_ff @(posedge clk) begin
    if (load_en && (state_q == IDLE || state_q == DONE)) begin
      store[load_addr] <= load_data;
    end
  end

  assign instr       = store[pc[PC_W-1:0]];
  assign ins_w       = instr[14:10];
  assign ins_r1      = instr[9:5];
  assign ins_r2      = instr[4:0];
  assign len_clamped = (prog_len > (PC_W+1)'(PROG_DEPTH)) ? (PC_W+1)'(PROG_DEPTH) : prog_len;

  // Hazard: a nonzero source matches any valid recently issued destination
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZARD_DEPTH; i++) begin
      if (hist_v_q[i] && (((ins_r1 != '0) && (ins_r1 == hist_a_q[i])) ||
                          ((ins_r2 != '0) && (ins_r2 == hist_a_q[i])))) begin
        hazard = 1'b1;
      end
    end
  end

  // Next-state, history and output decode
  always_comb begin
    state_d  = state_q;
    pc_d     = pc;
    len_d    = len_q;
    cnt_d    = cnt_q;
    hist_a_d = hist_a_q;
    hist_v_d = hist_v_q;
    shift    = 1'b0;
    shift_v  = 1'b0;
    shift_a  = '0;
    hist_clr = 1'b0;
    op_d     = '0;
    waddr_d  = '0;
    raddr1_d = '0;
    raddr2_d = '0;
    valid_d  = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pc_d     = '0;
          len_d    = len_clamped;
          hist_clr = 1'b1;
          if (len_clamped == '0) begin
            state_d = DRAIN;
            cnt_d   = DC_W'(DRAIN_CYCLES);
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        shift = 1'b1;
        if (!hazard) begin
          op_d     = instr[16:15];
          waddr_d  = ins_w;
          raddr1_d = ins_r1;
          raddr2_d = ins_r2;
          valid_d  = 1'b1;
          shift_v  = (ins_w != '0);
          shift_a  = ins_w;
          pc_d     = pc + (PC_W+1)'(1);
          if (pc == len_q - (PC_W+1)'(1)) begin
            state_d = DRAIN;
            cnt_d   = DC_W'(DRAIN_CYCLES);
          end
        end
      end
      DRAIN: begin
        shift = 1'b1;
        if (cnt_q <= DC_W'(1)) begin
          state_d  = DONE;
          cnt_d    = '0;
          done_d   = 1'b1;
          hist_clr = 1'b1;
        end else begin
          cnt_d = cnt_q - DC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // History ages every RUN/DRAIN cycle, bubbles shift in an invalid slot
    if (shift) begin
      for (int i = HAZARD_DEPTH - 1; i > 0; i--) begin
        hist_a_d[i] = hist_a_q[i-1];
        hist_v_d[i] = hist_v_q[i-1];
      end
      hist_a_d[0] = shift_a;
      hist_v_d[0] = shift_v;
    end
    if (hist_clr) begin
      for (int i = 0; i < HAZARD_DEPTH; i++) begin
        hist_a_d[i] = '0;
        hist_v_d[i] = 1'b0;
      end
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      pc       <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < HAZARD_DEPTH; i++) begin
        hist_a_q[i] <= '0;
        hist_v_q[i] <= 1'b0;
      end
      i_op     <= '0;
      i_waddr  <= '0;
      i_raddr1 <= '0;
      i_raddr2 <= '0;
      i_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc       <= pc_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < HAZARD_DEPTH; i++) begin
        hist_a_q[i] <= hist_a_d[i];
        hist_v_q[i] <= hist_v_d[i];
      end
      i_op     <= op_d;
      i_waddr  <= waddr_d;
      i_raddr1 <= raddr1_d;
      i_raddr2 <= raddr2_d;
      i_valid  <= valid_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Testbench for inst_sequencer: scenario tasks against an issue-schedule model.
module tb_inst_sequencer;
  localparam int unsigned PD = 32;
  localparam int unsigned PW = 5;
  localparam int unsigned HD = 3;
  localparam int unsigned DC = 3;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          load_en = 1'b0;
  logic [PW-1:0] load_addr = '0;
  logic [16:0]   load_data = '0;
  logic [PW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic [1:0]    i_op;
  logic [4:0]    i_waddr, i_raddr1, i_raddr2;
  logic          i_valid;
  logic [PW:0]   pc;
  logic          busy, done;

  int vectors = 0;
  int miscompares = 0;
  logic [16:0] mem [PD];

  inst_sequencer #(.PROG_DEPTH(PD), .PC_W(PW), .HAZARD_DEPTH(HD), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rstN(rstN), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .start(start), .i_op(i_op), .i_waddr(i_waddr), .i_raddr1(i_raddr1),
    .i_raddr2(i_raddr2), .i_valid(i_valid), .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] mk(input int op, input int w, input int r1, input int r2);
    return {2'(op), 5'(w), 5'(r1), 5'(r2)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [16:0] d);
    load_en = 1'b1; load_addr = PW'(a); load_data = d;
    tick();
    load_en = 1'b0;
    mem[a] = d;
  endtask

  // Start a run and check every output cycle against the model schedule.
  // Model: instruction j issues at the earliest cycle after its predecessor
  // such that every earlier producer of one of its nonzero sources was
  // issued at least HD+1 cycles before. DC bubbles follow the last issue.
  task automatic run_prog(input string name, input int len_in, input bit poke,
                          input bit ld, input int ld_addr, input logic [16:0] ld_data);
    int eff, last, issued, e;
    int t [PD];
    logic [16:0] ins;
    logic [25:0] got, exp;
    logic [4:0] w, r1, r2;
    if (ld) mem[ld_addr] = ld_data;
    eff = (len_in > int'(PD)) ? int'(PD) : len_in;
    last = 0;
    for (int j = 0; j < eff; j++) begin
      ins = mem[j];
      r1 = ins[9:5]; r2 = ins[4:0];
      e = last + 1;
      for (int m = 0; m < j; m++) begin
        w = mem[m][14:10];
        if (w != 0 && (r1 == w || r2 == w) && e < t[m] + int'(HD) + 1) e = t[m] + int'(HD) + 1;
      end
      t[j] = e;
      last = e;
    end
    prog_len = (PW+1)'(len_in);
    start = 1'b1;
    if (ld) begin
      load_en = 1'b1; load_addr = PW'(ld_addr); load_data = ld_data;
    end
    tick();
    start = 1'b0; load_en = 1'b0;
    for (int c = 0; c <= last + int'(DC) + 1; c++) begin
      ins = '0;
      issued = 0;
      exp[25] = 1'b0;
      for (int j = 0; j < eff; j++) begin
        if (t[j] == c) begin ins = mem[j]; exp[25] = 1'b1; end
        if (t[j] <= c) issued++;
      end
      exp[24:8] = ins;
      exp[7:2] = 6'(issued);
      exp[1] = (c < last + int'(DC));
      exp[0] = (c == last + int'(DC));
      got = {i_valid, i_op, i_waddr, i_raddr1, i_raddr2, pc, busy, done};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got {v,op,w,r1,r2,pc,busy,done}=%h want %h", name, c, got, exp);
      end
      if (poke && c == 1) begin
        start = 1'b1; load_en = 1'b1; load_addr = '0; load_data = ~mem[0]; prog_len = 6'd1;
      end
      if (poke && c == 2) begin
        start = 1'b0; load_en = 1'b0;
      end
      if (c < last + int'(DC) + 1) tick();
    end
  endtask

  task automatic test_reset();
    logic [25:0] got;
    got = {i_valid, i_op, i_waddr, i_raddr1, i_raddr2, pc, busy, done};
    vectors++;
    if (got !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", got);
    end
  endtask

  task automatic test_independent();
    load(0, mk(1, 1, 4, 5));
    load(1, mk(2, 2, 6, 7));
    load(2, mk(3, 3, 8, 9));
    run_prog("independent", 3, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic test_raw_distance();
    load(0, mk(1, 5, 20, 21));
    load(1, mk(2, 6, 22, 5));
    run_prog("raw_dist1", 2, 1'b0, 1'b0, 0, '0);
    for (int k = 1; k <= 3; k++) begin
      load(0, mk(1, 5, 20, 21));
      for (int u = 1; u <= k; u++) load(u, mk(0, 10 + u, 22, 23));
      load(k + 1, mk(3, 7, 5, 24));
      run_prog($sformatf("raw_gap%0d", k), k + 2, 1'b0, 1'b0, 0, '0);
    end
  endtask

  task automatic test_r0_self();
    load(0, mk(1, 0, 3, 4));
    load(1, mk(2, 9, 0, 0));
    run_prog("r0_sink", 2, 1'b0, 1'b0, 0, '0);
    load(0, mk(2, 7, 7, 7));
    run_prog("self_read", 1, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic test_zero_len_and_ignore();
    run_prog("zero_len", 0, 1'b0, 1'b0, 0, '0);
    load(0, mk(1, 4, 1, 2));
    load(1, mk(2, 8, 4, 3));
    load(2, mk(3, 9, 8, 8));
    run_prog("start_in_run", 3, 1'b1, 1'b0, 0, '0);
    run_prog("after_ignored_load", 3, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic test_load_with_start();
    run_prog("load_same_edge", 1, 1'b0, 1'b1, 0, mk(3, 12, 13, 14));
  endtask

  task automatic test_reset_mid();
    logic [25:0] got;
    load(0, mk(1, 5, 1, 2));
    load(1, mk(2, 6, 5, 3));
    prog_len = 6'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rstN = 1'b0;
    #1;
    got = {i_valid, i_op, i_waddr, i_raddr1, i_raddr2, pc, busy, done};
    vectors++;
    if (got !== 26'd0) begin
      miscompares++;
      $display("FAIL async_reset_mid_stall: got %h want 0", got);
    end
    @(negedge clk) rstN = 1'b1;
    tick();
    got = {i_valid, i_op, i_waddr, i_raddr1, i_raddr2, pc, busy, done};
    vectors++;
    if (got !== 26'd0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %h want 0", got);
    end
    run_prog("rerun_after_reset", 2, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(0, 10);
      for (int j = 0; j < n; j++)
        load(j, mk($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
      run_prog($sformatf("random%0d", it), n, it[0], 1'b0, 0, '0);
    end
    for (int j = 0; j < int'(PD); j++)
      load(j, mk($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
    run_prog("clamp_len", 40, 1'b0, 1'b0, 0, '0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    tick();
    test_reset();
    test_independent();
    test_raw_distance();
    test_r0_self();
    test_zero_len_and_ignore();
    test_load_with_start();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
